ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 136 +++++++++++++
 tb/tb_ahb_slave_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mem
// Brief    : AHB-Lite slave backed by a small word-addressed memory, with
//            configurable data-phase wait states and a two-cycle ERROR
//            response for bad size, misaligned or out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_mem #(
  parameter int ADDR_WORDS  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int         c_IDX_W    = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam logic [2:0] c_WAIT_CNT = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e               state_q;
  logic [2:0]           cnt_q;
  logic [c_IDX_W-1:0]   idx_q;
  logic                 write_q;
  logic                 hreadyout_q;
  logic                 hresp_q;
  logic [31:0]          mem_q [ADDR_WORDS];

  logic w_accept;
  logic w_range_err;
  logic w_xfer_err;
  logic w_unused;

  // HTRANS[0] only separates NONSEQ from SEQ and BUSY from IDLE; neither
  // distinction changes how this slave responds.
  assign w_unused    = HTRANS[0];

  // A transfer is taken only when selected, the bus is ready and it is
  // NONSEQ or SEQ.
  assign w_accept    = HSEL & HREADY & HTRANS[1];

  // Any address bit above the word index means the word is past the end of
  // storage (depth is a power of two).
  assign w_range_err = |HADDR[31:c_IDX_W+2];
  assign w_xfer_err  = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00) | w_range_err;

  // Transfer FSM: address-phase capture, wait-state countdown and
  // registered HREADYOUT / HRESP.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_q     <= S_DONE;
            cnt_q       <= 3'd0;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        // IDLE, DONE and ERR2 all present HREADYOUT=1, so each may take the
        // next address phase; unknown encodings fall through here as well.
        default: begin
          if (w_accept) begin
            idx_q   <= HADDR[c_IDX_W+1:2];
            write_q <= HWRITE;
            if (w_xfer_err) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q     <= S_WAIT;
              cnt_q       <= c_WAIT_CNT;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= S_DONE;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Write data is committed on the edge that ends a write data phase; a reset
  // during the transfer has already moved the FSM out of DONE, so nothing lands.
  always_ff @(posedge HCLK) begin
    if (HRESETn && (state_q == S_DONE) && write_q) begin
      mem_q[idx_q] <= HWDATA;
    end
  end

  // Read data is driven straight from storage during a read DONE, so a read
  // right behind a write to the same word sees the freshly committed value.
  assign HRDATA    = ((state_q == S_DONE) && !write_q) ? mem_q[idx_q] : 32'h0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_slave_mem
// Brief    : Directed bench for ahb_slave_mem: a cycle table against a
//            zero-wait instance and hand sequences against a three-wait one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mem;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic HCLK;
  logic HRESETn;

  // Zero-wait-state instance signals
  logic        sel0, write0, hready0, hrdy0, hresp0;
  logic [31:0] addr0, wdata0, hrdata0;
  logic [1:0]  trans0;
  logic [2:0]  size0;

  // Three-wait-state instance signals
  logic        sel3, write3, hready3, hrdy3, hresp3;
  logic [31:0] addr3, wdata3, hrdata3;
  logic [1:0]  trans3;
  logic [2:0]  size3;

  int vectors;
  int miscompares;

  // Single-slave bus: the bus-wide ready is this slave's own ready.
  assign hready0 = hrdy0;
  assign hready3 = hrdy3;

  ahb_slave_mem #(.ADDR_WORDS(16), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(addr0),
    .HTRANS(trans0), .HWRITE(write0), .HSIZE(size0), .HWDATA(wdata0),
    .HREADY(hready0), .HRDATA(hrdata0), .HREADYOUT(hrdy0), .HRESP(hresp0)
  );

  ahb_slave_mem #(.ADDR_WORDS(16), .WAIT_STATES(3)) u_dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel3), .HADDR(addr3),
    .HTRANS(trans3), .HWRITE(write3), .HSIZE(size3), .HWDATA(wdata3),
    .HREADY(hready3), .HRDATA(hrdata3), .HREADYOUT(hrdy3), .HRESP(hresp3)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                              input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input logic e_rdy,
                              input logic e_rsp, input logic [31:0] e_rdata);
    vec_t v;
    v.sel = sel; v.trans = trans; v.wr = wr; v.addr = addr; v.size = size;
    v.wdata = wdata; v.e_rdy = e_rdy; v.e_rsp = e_rsp; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check3(input string name, input logic rdy, input logic rsp,
                        input logic [31:0] rd);
    vectors++;
    if (hrdy3 !== rdy || hresp3 !== rsp || hrdata3 !== rd) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
               name, hrdy3, hresp3, hrdata3, rdy, rsp, rd);
    end
  endtask

  // One transfer on the three-wait instance, starting from an idle bus.
  task automatic xfer3(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lows, output logic [31:0] rd, output logic rsp);
    sel3 = 1'b1; trans3 = T_NS; write3 = wr; addr3 = addr; size3 = 3'b010;
    @(posedge HCLK); #1;
    trans3 = T_IDLE; wdata3 = wdata;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      if (hrdy3) break;
      lows++;
    end
    rd  = hrdata3;
    rsp = hresp3;
    @(posedge HCLK); #1;
  endtask

  initial begin
    int          lows;
    logic [31:0] rd;
    logic        rsp;

    vectors = 0;
    miscompares = 0;

    //             sel trans  wr   addr          sz    wdata         rdy rsp rdata
    tbl[0]  = mk(1, T_NS,   1, 32'h00, 3'b010, 32'h0,        1, 0, 32'h0);        // reset state; write 0x00
    tbl[1]  = mk(1, T_NS,   1, 32'h04, 3'b010, 32'hA5A5A5A5, 1, 0, 32'h0);        // data 0x00; write 0x04
    tbl[2]  = mk(1, T_SEQ,  0, 32'h04, 3'b010, 32'hDEADBEEF, 1, 0, 32'h0);        // data 0x04; read 0x04
    tbl[3]  = mk(1, T_NS,   0, 32'h00, 3'b010, 32'h0,        1, 0, 32'hDEADBEEF); // read back-to-back
    tbl[4]  = mk(1, T_IDLE, 0, 32'h00, 3'b010, 32'h0,        1, 0, 32'hA5A5A5A5);
    tbl[5]  = mk(1, T_NS,   1, 32'h40, 3'b010, 32'h0,        1, 0, 32'h0);        // out of range
    tbl[6]  = mk(1, T_IDLE, 0, 32'h00, 3'b010, 32'h12345678, 0, 1, 32'h0);        // ERR1
    tbl[7]  = mk(1, T_NS,   1, 32'h04, 3'b000, 32'h0,        1, 1, 32'h0);        // ERR2; byte size
    tbl[8]  = mk(1, T_IDLE, 0, 32'h00, 3'b010, 32'h0BADF00D, 0, 1, 32'h0);
    tbl[9]  = mk(1, T_NS,   1, 32'h02, 3'b010, 32'h0,        1, 1, 32'h0);        // ERR2; misaligned
    tbl[10] = mk(1, T_IDLE, 0, 32'h00, 3'b010, 32'hCAFECAFE, 0, 1, 32'h0);
    tbl[11] = mk(1, T_IDLE, 0, 32'h00, 3'b010, 32'h0,        1, 1, 32'h0);
    tbl[12] = mk(0, T_NS,   1, 32'h04, 3'b010, 32'h0,        1, 0, 32'h0);        // unselected write
    tbl[13] = mk(1, T_BUSY, 1, 32'h04, 3'b010, 32'h55555555, 1, 0, 32'h0);        // BUSY write
    tbl[14] = mk(1, T_NS,   0, 32'h04, 3'b010, 32'h66666666, 1, 0, 32'h0);
    tbl[15] = mk(1, T_NS,   0, 32'h00, 3'b010, 32'h0,        1, 0, 32'hDEADBEEF); // 0x04 untouched
    tbl[16] = mk(1, T_IDLE, 0, 32'h00, 3'b010, 32'h0,        1, 0, 32'hA5A5A5A5); // 0x00 untouched
    tbl[17] = mk(1, T_IDLE, 0, 32'h00, 3'b010, 32'h0,        1, 0, 32'h0);

    HRESETn = 1'b0;
    sel0 = 1'b0; trans0 = T_IDLE; write0 = 1'b0; addr0 = '0; size0 = 3'b010; wdata0 = '0;
    sel3 = 1'b0; trans3 = T_IDLE; write3 = 1'b0; addr3 = '0; size3 = 3'b010; wdata3 = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Reset state of the wait-state instance
    @(negedge HCLK);
    check3("ws3_reset_state", 1'b1, 1'b0, 32'h0);
    @(posedge HCLK); #1;

    // Zero-wait cycle table
    for (int i = 0; i < 18; i++) begin
      sel0 = tbl[i].sel; trans0 = tbl[i].trans; write0 = tbl[i].wr;
      addr0 = tbl[i].addr; size0 = tbl[i].size; wdata0 = tbl[i].wdata;
      @(negedge HCLK);
      vectors++;
      if (hrdy0 !== tbl[i].e_rdy || hresp0 !== tbl[i].e_rsp || hrdata0 !== tbl[i].e_rdata) begin
        miscompares++;
        $display("FAIL ws0_vec%0d: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 i, hrdy0, hresp0, hrdata0, tbl[i].e_rdy, tbl[i].e_rsp, tbl[i].e_rdata);
      end
      @(posedge HCLK); #1;
    end

    // Three wait states: write 0x08, then read it back
    xfer3(1'b1, 32'h08, 32'h87654321, lows, rd, rsp);
    vectors++;
    if (lows != 3 || rsp !== 1'b0) begin
      miscompares++;
      $display("FAIL ws3_write08: got low_cycles=%0d resp=%b, want low_cycles=3 resp=0", lows, rsp);
    end
    xfer3(1'b0, 32'h08, 32'h0, lows, rd, rsp);
    vectors++;
    if (lows != 3 || rsp !== 1'b0 || rd !== 32'h87654321) begin
      miscompares++;
      $display("FAIL ws3_read08: got low_cycles=%0d resp=%b rdata=%h, want 3 0 87654321",
               lows, rsp, rd);
    end

    // Prior value for 0x0C
    xfer3(1'b1, 32'h0C, 32'h0C0C0C0C, lows, rd, rsp);
    vectors++;
    if (lows != 3) begin
      miscompares++;
      $display("FAIL ws3_write0C: got low_cycles=%0d, want 3", lows);
    end

    // Write to 0x0C aborted by reset during WAIT
    sel3 = 1'b1; trans3 = T_NS; write3 = 1'b1; addr3 = 32'h0C; size3 = 3'b010;
    @(posedge HCLK); #1;
    trans3 = T_IDLE; wdata3 = 32'hFFFFFFFF;
    @(negedge HCLK);
    check3("ws3_in_wait", 1'b0, 1'b0, 32'h0);
    #2 HRESETn = 1'b0;
    #1 check3("ws3_async_reset", 1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge HCLK);
    #1 check3("ws3_held_reset", 1'b1, 1'b0, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    // The read is presented so that the first edge after release must take it
    xfer3(1'b0, 32'h0C, 32'h0, lows, rd, rsp);
    vectors++;
    if (lows != 3 || rsp !== 1'b0 || rd !== 32'h0C0C0C0C) begin
      miscompares++;
      $display("FAIL ws3_read0C_after_reset: got low_cycles=%0d resp=%b rdata=%h, want 3 0 0c0c0c0c",
               lows, rsp, rd);
    end
    @(negedge HCLK);
    check3("ws3_idle_after", 1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
